// File: rtl/branch_predictor_if.sv
// Fetch-side bundle between the IF/ID pipeline and the branch target buffer.
// master: pipeline side (drives lookup PC, resolved-branch updates, flush).
// slave : predictor side (returns hit/prediction and optional statistics).
// Ports : pc_i (lookup), hit_o/pred_taken_o/pred_pc_o (prediction),
//         upd_* (training from ID), flush_i, upd_cnt_o/mispred_cnt_o (stats).
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  // lookup
  logic [ADDR_W-1:0] pc_i;
  logic              hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_pc_o;
  // training
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_i;
  logic              flush_i;
  // statistics
  logic [31:0]       upd_cnt_o;
  logic [31:0]       mispred_cnt_o;

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_i, flush_i,
    input  hit_o, pred_taken_o, pred_pc_o, upd_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_i, flush_i,
    output hit_o, pred_taken_o, pred_pc_o, upd_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Purpose : direct-mapped branch target buffer with saturating direction counters.
// Latency : lookup is combinational (0 cycles); updates visible from the next cycle.
// Backpressure: none -- every lookup and every update is accepted each cycle.
// Ports   : clk_i, rst_i (synchronous, active-low), bp (branch_predictor_if.slave).
// Option  : define BRANCH_PRED_STATS_EN to build the update/misprediction counters;
//           otherwise upd_cnt_o/mispred_cnt_o are tied to 0.
module branch_predictor #(
  parameter int ENTRIES = 16,  // power of two, >= 2
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2    // >= 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  branch_predictor_if.slave   bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  // Fresh allocations start weakly taken: MSB set, remaining bits clear.
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational from pc_i and the registered table. A write to
  // the same index in this cycle is not bypassed, so the old contents show.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_entry;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx   = bp.pc_i[IDX_W+1:2];
  assign lk_tag   = bp.pc_i[ADDR_W-1:IDX_W+2];
  assign lk_entry = table_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lk_taken = lk_hit && lk_entry.ctr[CTR_W-1];

  assign bp.hit_o        = lk_hit;
  assign bp.pred_taken_o = lk_taken;
  // Fall-through wraps naturally at the top of the address space.
  assign bp.pred_pc_o    = lk_taken ? lk_entry.target : (bp.pc_i + ADDR_W'(4));

  // ---------------------------------------------------------------------------
  // Training: build the replacement entry for the indexed slot.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  entry_t           upd_old;
  logic             upd_hit;
  entry_t           upd_entry;
  logic             upd_we;

  assign upd_idx = bp.upd_pc_i[IDX_W+1:2];
  assign upd_tag = bp.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_old = table_q[upd_idx];
  assign upd_hit = upd_old.valid && (upd_old.tag == upd_tag);

  always_comb begin
    upd_we    = 1'b0;
    upd_entry = upd_old;
    if (bp.upd_valid_i) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (bp.upd_taken_i) begin
          upd_entry.ctr    = (upd_old.ctr == CTR_MAX) ? CTR_MAX : upd_old.ctr + CTR_W'(1);
          upd_entry.target = bp.upd_target_i;
        end else begin
          upd_entry.ctr    = (upd_old.ctr == CTR_ZERO) ? CTR_ZERO : upd_old.ctr - CTR_W'(1);
        end
      end else if (bp.upd_taken_i) begin
        // Taken miss evicts whatever occupied this index (tag alias or stale).
        upd_we           = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = upd_tag;
        upd_entry.target = bp.upd_target_i;
        upd_entry.ctr    = CTR_WEAK;
      end
      // Not-taken miss: nothing worth remembering.
    end
  end

  // Reset beats flush beats update. Flush drops only valid bits so the stale
  // payload is harmless; a coincident update is discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
    end else if (bp.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (upd_we) begin
      table_q[upd_idx] <= upd_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics.
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] upd_cnt_q;
  logic [31:0] mispred_cnt_q;
  logic        upd_accept;
  logic        upd_mispred;

  assign upd_accept  = bp.upd_valid_i && !bp.flush_i;
  assign upd_mispred = bp.upd_pred_i != bp.upd_taken_i;

  // Flush leaves these alone; only reset clears them. Both stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else if (upd_accept) begin
      if (upd_cnt_q != 32'hFFFF_FFFF) begin
        upd_cnt_q <= upd_cnt_q + 32'd1;
      end
      if (upd_mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign bp.upd_cnt_o     = upd_cnt_q;
  assign bp.mispred_cnt_o = mispred_cnt_q;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0]};
`else
  assign bp.upd_cnt_o     = '0;
  assign bp.mispred_cnt_o = '0;

  // The carried-down prediction only matters to the statistics.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0], bp.upd_pred_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random traffic,
// every cycle compared against a behavioural table model kept here.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int CTR_W   = 2;
  localparam int CMAX    = (1 << CTR_W) - 1;
  localparam int CWEAK   = 1 << (CTR_W - 1);
`ifdef BRANCH_PRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(ADDR_W)) bp_if ();

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bp    (bp_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a table of remembered branches keyed by slot, each slot
  // remembering the full word address that owns it.
  bit          m_init = 1'b0;
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      m_upd, m_mis;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s] && ((m_owner[s] >> 2) == (pc >> 2));
  endfunction

  // Values seen at the most recent mid-cycle sample.
  logic        s_hit, s_taken;
  logic [31:0] s_pc, s_ucnt, s_mcnt;

  task automatic check_outputs(input logic [31:0] pc);
    bit          h  = m_hit(pc);
    bit          t  = h && (m_ctr[slot(pc)] >= CWEAK);
    logic [31:0] np = t ? m_tgt[slot(pc)] : pc + 32'd4;
    chk("hit", {63'd0, bp_if.hit_o}, {63'd0, h});
    chk("taken", {63'd0, bp_if.pred_taken_o}, {63'd0, t});
    chk("pred_pc", {32'd0, bp_if.pred_pc_o}, {32'd0, np});
    chk("upd_cnt", {32'd0, bp_if.upd_cnt_o}, STATS ? 64'(m_upd) : 64'd0);
    chk("mispred_cnt", {32'd0, bp_if.mispred_cnt_o}, STATS ? 64'(m_mis) : 64'd0);
  endtask

  task automatic model_edge(input logic uv, input logic [31:0] upc, input logic ut,
                            input logic [31:0] utgt, input logic up, input logic fl,
                            input logic rst);
    int s = slot(upc);
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_ctr[i] = 0; m_tgt[i] = '0; m_owner[i] = '0;
      end
      m_upd = 0; m_mis = 0; m_init = 1'b1;
    end else if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[s] = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
          m_tgt[s] = utgt;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (ut) begin
        m_valid[s] = 1'b1; m_owner[s] = upc; m_tgt[s] = utgt; m_ctr[s] = CWEAK;
      end
      if (m_upd < 64'hFFFF_FFFF) m_upd++;
      if (up != ut && m_mis < 64'hFFFF_FFFF) m_mis++;
    end
  endtask

  // One cycle: drive inputs, sample mid-cycle, then take the edge.
  task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic up,
                       input logic fl, input logic rst);
    bp_if.pc_i = pc; bp_if.upd_valid_i = uv; bp_if.upd_pc_i = upc;
    bp_if.upd_taken_i = ut; bp_if.upd_target_i = utgt; bp_if.upd_pred_i = up;
    bp_if.flush_i = fl; rst_n = rst;
    @(negedge clk);
    s_hit = bp_if.hit_o; s_taken = bp_if.pred_taken_o; s_pc = bp_if.pred_pc_o;
    s_ucnt = bp_if.upd_cnt_o; s_mcnt = bp_if.mispred_cnt_o;
    if (m_init) check_outputs(pc);
    @(posedge clk);
    model_edge(uv, upc, ut, utgt, up, fl, rst);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    drive(pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic up);
    drive(upc, 1'b1, upc, ut, utgt, up, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 19) == 0) p = 32'hFFFF_FFC0 | ($urandom_range(0, 15) << 2);
    else p = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
    return p | $urandom_range(0, 3);
  endfunction

  initial begin
    // Reset, then an empty-table lookup.
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_hit", {63'd0, s_hit}, 64'd0);
    chk("rst_pred_pc", {32'd0, s_pc}, 64'h44);
    chk("rst_ucnt", {32'd0, s_ucnt}, 64'd0);

    // Allocate, then hit weakly taken.
    upd(32'h40, 1'b1, 32'h80, 1'b0);
    look(32'h40);
    chk("alloc_hit", {63'd0, s_hit}, 64'd1);
    chk("alloc_taken", {63'd0, s_taken}, 64'd1);
    chk("alloc_pc", {32'd0, s_pc}, 64'h80);

    // Saturate high, then fall to zero.
    repeat (3) upd(32'h40, 1'b1, 32'h80, 1'b1);
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h40);
    chk("sat_hi_taken", {63'd0, s_taken}, 64'd1);
    repeat (2) upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    chk("sat_lo_hit", {63'd0, s_hit}, 64'd1);
    chk("sat_lo_taken", {63'd0, s_taken}, 64'd0);
    chk("sat_lo_pc", {32'd0, s_pc}, 64'h44);

    // Alias eviction at index 0.
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    chk("alias_old_miss", {63'd0, s_hit}, 64'd0);
    look(32'h80);
    chk("alias_new_hit", {63'd0, s_hit}, 64'd1);
    chk("alias_new_pc", {32'd0, s_pc}, 64'h200);

    // Same-cycle update returns pre-update contents.
    drive(32'h80, 1'b1, 32'h80, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("nobypass_taken", {63'd0, s_taken}, 64'd1);
    look(32'h80);
    chk("after_dec_taken", {63'd0, s_taken}, 64'd0);
    chk("after_dec_pc", {32'd0, s_pc}, 64'h84);

    // Flush with a coincident update: table empty, update dropped.
    drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    look(32'h40);
    chk("flush_miss40", {63'd0, s_hit}, 64'd0);
    look(32'h80);
    chk("flush_miss80", {63'd0, s_hit}, 64'd0);

    // Address wrap on fall-through.
    look(32'hFFFF_FFFC);
    chk("wrap_pc", {32'd0, s_pc}, 64'h0);

    // Statistics: 5 updates, 2 mispredicted; survive flush, clear on reset.
    drive(32'h0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    upd(32'h100, 1'b1, 32'h10, 1'b1);
    upd(32'h104, 1'b0, 32'h10, 1'b1);
    upd(32'h108, 1'b1, 32'h10, 1'b1);
    upd(32'h100, 1'b1, 32'h10, 1'b0);
    upd(32'h10C, 1'b0, 32'h10, 1'b0);
    look(32'h0);
    chk("stats_upd", {32'd0, s_ucnt}, STATS ? 64'd5 : 64'd0);
    chk("stats_mis", {32'd0, s_mcnt}, STATS ? 64'd2 : 64'd0);
    drive(32'h0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    look(32'h0);
    chk("stats_flush_upd", {32'd0, s_ucnt}, STATS ? 64'd5 : 64'd0);
    chk("stats_flush_mis", {32'd0, s_mcnt}, STATS ? 64'd2 : 64'd0);
    drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    look(32'h0);
    chk("stats_rst_upd", {32'd0, s_ucnt}, 64'd0);
    chk("stats_rst_mis", {32'd0, s_mcnt}, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] lpc, upc;
      lpc = rand_pc();
      upc = ($urandom_range(0, 3) == 0) ? lpc : rand_pc();
      drive(lpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
            !($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
